// File: rtl/fft_input_sequencer.sv
// Input-side frame sequencer for the 64-point FFT: accepts 64 samples, writes them to the
// core's input buffer, and pulses start. Define FFT_INPUT_BITREV_EN for bit-reversed (DIT) addressing.
module fft_input_sequencer #(
   parameter int DW     = 16,
   parameter int N_LOG2 = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DW-1:0]       in_re,
   input  logic [DW-1:0]       in_im,
   input  logic                in_last,
   output logic                wr_en,
   output logic [N_LOG2-1:0]   wr_addr,
   output logic [DW-1:0]       wr_re,
   output logic [DW-1:0]       wr_im,
   output logic                start_o,
   input  logic                core_done,
   output logic                frame_err,
   input  logic                err_clr
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      START = 2'd2,
      WAIT  = 2'd3
   } state_t;

   localparam logic [N_LOG2-1:0] CNT_ONE  = N_LOG2'(1);
   localparam logic [N_LOG2-1:0] CNT_LAST = '1;

   function automatic logic [N_LOG2-1:0] map_addr(input logic [N_LOG2-1:0] cnt);
      logic [N_LOG2-1:0] addr;
`ifdef FFT_INPUT_BITREV_EN
      for (int i = 0; i < N_LOG2; i++) begin
         addr[i] = cnt[N_LOG2-1-i];
      end
`else
      addr = cnt;
`endif
      return addr;
   endfunction

   state_t              state_q, state_d;
   logic [N_LOG2-1:0]   count_q, count_d;
   logic                wr_en_q, wr_en_d;
   logic [N_LOG2-1:0]   wr_addr_q, wr_addr_d;
   logic [DW-1:0]       wr_re_q, wr_re_d;
   logic [DW-1:0]       wr_im_q, wr_im_d;
   logic                start_q, start_d;
   logic                frame_err_q, frame_err_d;
   logic                ready_s;
   logic                accept_s;
   logic                last_pos_s;

   // Ready decode: only the two loading states accept, and never while in reset.
   always_comb begin
      ready_s = 1'b0;
      if (rst) begin
         ready_s = 1'b0;
      end else if ((state_q == IDLE) || (state_q == LOAD)) begin
         ready_s = 1'b1;
      end else begin
         ready_s = 1'b0;
      end
   end

   assign accept_s   = in_valid & ready_s;
   assign last_pos_s = (count_q == CNT_LAST);

   // Next-state, counter, write-port and error-flag logic.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_re_d     = wr_re_q;
      wr_im_d     = wr_im_q;
      start_d     = (state_q == START);
      frame_err_d = frame_err_q;

      if (accept_s) begin
         wr_en_d   = 1'b1;
         wr_addr_d = map_addr(count_q);
         wr_re_d   = in_re;
         wr_im_d   = in_im;
         count_d   = count_q + CNT_ONE;
      end else begin
         count_d = count_q;
      end

      // Set beats clear; in_last is only checked, framing always follows the counter.
      if (accept_s && (in_last != last_pos_s)) begin
         frame_err_d = 1'b1;
      end else if (err_clr) begin
         frame_err_d = 1'b0;
      end else begin
         frame_err_d = frame_err_q;
      end

      case (state_q)
         IDLE: begin
            if (accept_s) begin
               state_d = LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            if (accept_s && last_pos_s) begin
               state_d = START;
            end else begin
               state_d = LOAD;
            end
         end
         START: begin
            state_d = WAIT;
         end
         WAIT: begin
            if (core_done) begin
               state_d = IDLE;
            end else begin
               state_d = WAIT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         count_q     <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_re_q     <= '0;
         wr_im_q     <= '0;
         start_q     <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_re_q     <= wr_re_d;
         wr_im_q     <= wr_im_d;
         start_q     <= start_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign in_ready  = ready_s;
   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_re     = wr_re_q;
   assign wr_im     = wr_im_q;
   assign start_o   = start_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_fft_input_sequencer.sv
// Randomized bench for fft_input_sequencer against a frame-level reference model.
// Build with FFT_INPUT_BITREV_EN to check the bit-reversed addressing build.
module tb_fft_input_sequencer;

   localparam int DW = 16;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_re;
   logic [DW-1:0] in_im;
   logic          in_last;
   logic          wr_en;
   logic [5:0]    wr_addr;
   logic [DW-1:0] wr_re;
   logic [DW-1:0] wr_im;
   logic          start_o;
   logic          core_done;
   logic          frame_err;
   logic          err_clr;

   int n_vec;
   int n_miss;

   fft_input_sequencer #(.DW(DW), .N_LOG2(6)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_re     (in_re),
      .in_im     (in_im),
      .in_last   (in_last),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_re     (wr_re),
      .wr_im     (wr_im),
      .start_o   (start_o),
      .core_done (core_done),
      .frame_err (frame_err),
      .err_clr   (err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
      end
   endtask

   // Buffer address for the k-th sample of a frame.
   function automatic int exp_addr(input int k);
      int r;
      int c;
      r = 0;
      c = k;
`ifdef FFT_INPUT_BITREV_EN
      for (int b = 0; b < 6; b++) begin
         r = r * 2 + (c % 2);
         c = c / 2;
      end
`else
      r = c;
`endif
      return r;
   endfunction

   // Reference model: samples taken in the current frame, busy once 64 are in,
   // and how many cycles have elapsed since the frame filled.
   int   m_filled;
   bit   m_busy;
   int   m_age;
   bit   e_wr_en;
   int   e_addr;
   int   e_re;
   int   e_im;
   bit   e_start;
   bit   e_err;
   bit   acc;
   bit   e_ready;
   bit   done_seen;
   bit   new_start;
   int   vprob;
   int   frames;

   task automatic model_reset();
      m_filled = 0;
      m_busy   = 1'b0;
      m_age    = 0;
      e_wr_en  = 1'b0;
      e_addr   = 0;
      e_re     = 0;
      e_im     = 0;
      e_start  = 1'b0;
      e_err    = 1'b0;
   endtask

   initial begin
      n_vec     = 0;
      n_miss    = 0;
      frames    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_re     = '0;
      in_im     = '0;
      in_last   = 1'b0;
      core_done = 1'b0;
      err_clr   = 1'b0;
      model_reset();

      for (int c = 0; c < 8000; c++) begin
         // Drive this cycle's inputs away from the clock edge.
         vprob = (c / 1000) % 4;
         rst   = (c < 3) || ($urandom_range(0, 999) == 0);
         case (vprob)
            0:       in_valid = 1'b1;
            1:       in_valid = ($urandom_range(0, 1) == 1);
            2:       in_valid = (c % 2 == 0);
            default: in_valid = ($urandom_range(0, 3) != 0);
         endcase
         in_re     = DW'($urandom);
         in_im     = DW'($urandom);
         in_last   = (m_filled == 63);
         if ($urandom_range(0, 39) == 0) in_last = ~in_last;
         core_done = ($urandom_range(0, 9) == 0);
         err_clr   = ($urandom_range(0, 29) == 0);
         #1;

         e_ready = !rst && !m_busy;
         chk("in_ready", 32'(in_ready), 32'(e_ready));

         if (rst) begin
            model_reset();
         end else begin
            acc       = in_valid && e_ready;
            new_start = m_busy && (m_age == 0);
            done_seen = m_busy && (m_age >= 1) && core_done;
            if (acc && (in_last != (m_filled == 63))) e_err = 1'b1;
            else if (err_clr)                         e_err = 1'b0;
            e_start = new_start;
            if (acc) begin
               e_wr_en = 1'b1;
               e_addr  = exp_addr(m_filled);
               e_re    = int'(in_re);
               e_im    = int'(in_im);
               m_filled++;
               if (m_filled == 64) begin
                  m_filled = 0;
                  m_busy   = 1'b1;
                  m_age    = 0;
                  frames++;
               end
            end else begin
               e_wr_en = 1'b0;
               if (done_seen) begin
                  m_busy = 1'b0;
               end else if (m_busy && m_age < 1000) begin
                  m_age++;
               end
            end
         end

         @(posedge clk);
         #1;
         chk("wr_en",     32'(wr_en),     32'(e_wr_en));
         chk("wr_addr",   32'(wr_addr),   32'(e_addr));
         chk("wr_re",     32'(wr_re),     32'(e_re));
         chk("wr_im",     32'(wr_im),     32'(e_im));
         chk("start_o",   32'(start_o),   32'(e_start));
         chk("frame_err", 32'(frame_err), 32'(e_err));
      end

      chk("frames_completed_nonzero", 32'(frames > 10), 32'(1));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
